// File: rtl/pipeline_ctrl_pkg.sv
// Control-word layout, ALU encodings and the RAW match helper shared by the
// pipeline control block and its stage registers.
package pipeline_ctrl_pkg;

    localparam int CTRL_W      = 22;
    localparam int RS_A_MSB    = 21;
    localparam int RS_A_LSB    = 17;
    localparam int RS_B_MSB    = 16;
    localparam int RS_B_LSB    = 12;
    localparam int MUX_B_IMM   = 11;
    localparam int MUX_ALU_MUL = 10;
    localparam int ALU_OP_MSB  = 9;
    localparam int ALU_OP_LSB  = 8;
    localparam int MEM_WR      = 7;
    localparam int MUX_WB      = 6;
    localparam int RD_MSB      = 5;
    localparam int RD_LSB      = 1;
    localparam int WRITE_RF    = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 22'd0;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    // r0 is hard-wired zero, so neither a zero source nor a zero destination can conflict
    function automatic logic raw_match(input logic [CTRL_W-1:0] word, input logic [4:0] src);
        return (src != 5'd0) && word[WRITE_RF] && (word[RD_MSB:RD_LSB] == src);
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage: a control word plus valid bit, with hold and bubble insertion.
module ctrl_stage_reg
    import pipeline_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              load_nop,
    input  logic [CTRL_W-1:0] d,
    input  logic              d_valid,
    output logic [CTRL_W-1:0] q,
    output logic              q_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= CTRL_NOP;
            q_valid <= 1'b0;
        end else if (!hold) begin
            if (load_nop) begin
                q       <= CTRL_NOP;
                q_valid <= 1'b0;
            end else begin
                q       <= d;
                q_valid <= d_valid;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_control.sv
// Carries decoded control through EX/MEM/WB, stalls decode on RAW hazards by
// injecting bubbles into EX, and keeps saturating stall/retire counters.
module pipeline_hazard_control
    import pipeline_ctrl_pkg::*;
#(
    parameter bit BYPASS_WB = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              freeze,
    input  logic              flush,
    output logic              stall,
    output logic [3:0]        ex_ctrl,
    output logic              mem_wr,
    output logic              wb_mux,
    output logic [4:0]        wb_rd,
    output logic              wb_write_rf,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  retire_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CTRL_W-1:0] ex_word, mem_word, wb_word;
    logic              ex_valid, mem_valid, wb_valid;
    logic [4:0]        rs_a, rs_b;
    logic              hazard;
    logic              bubble;
    logic              unused_wb_bits;

    assign rs_a = ctrl_in[RS_A_MSB:RS_A_LSB];
    assign rs_b = ctrl_in[RS_B_MSB:RS_B_LSB];

    // With a bypassing register file the WB writer is visible to same-cycle reads
    always_comb begin
        hazard = raw_match(ex_word, rs_a)  || raw_match(ex_word, rs_b) ||
                 raw_match(mem_word, rs_a) || raw_match(mem_word, rs_b);
        if (BYPASS_WB == 1'b0) begin
            hazard = hazard || raw_match(wb_word, rs_a) || raw_match(wb_word, rs_b);
        end
    end

    assign bubble = flush || hazard;
    assign stall  = freeze || (!flush && hazard);

    ctrl_stage_reg u_ex (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (freeze),
        .load_nop (bubble),
        .d        (ctrl_in),
        .d_valid  (ctrl_in != CTRL_NOP),
        .q        (ex_word),
        .q_valid  (ex_valid)
    );

    ctrl_stage_reg u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (freeze),
        .load_nop (1'b0),
        .d        (ex_word),
        .d_valid  (ex_valid),
        .q        (mem_word),
        .q_valid  (mem_valid)
    );

    ctrl_stage_reg u_wb (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (freeze),
        .load_nop (1'b0),
        .d        (mem_word),
        .d_valid  (mem_valid),
        .q        (wb_word),
        .q_valid  (wb_valid)
    );

    assign ex_ctrl        = ex_word[MUX_B_IMM:ALU_OP_LSB];
    assign mem_wr         = mem_word[MEM_WR];
    assign wb_mux         = wb_word[MUX_WB];
    assign wb_rd          = wb_word[RD_MSB:RD_LSB];
    assign wb_write_rf    = wb_word[WRITE_RF];
    assign unused_wb_bits = ^wb_word[CTRL_W-1:MEM_WR];

    // A flushed hazard is not a stall, so it must not be counted as one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count  <= '0;
            retire_count <= '0;
        end else if (!freeze) begin
            if (!flush && hazard && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (wb_valid && (retire_count != CNT_MAX)) begin
                retire_count <= retire_count + 1'b1;
            end
        end
    end

endmodule
